// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder that reuses a single 4-bit carry-lookahead
// slice.
// - Both operands and the carry-in are captured when a start is accepted.
// - One nibble is added per clock, least significant nibble first.
// - The carry between nibbles is held in a register.
// - Choose this block when area matters more than latency.
//
// Optional feature (compile-time macro NSA_OVERFLOW_EN):
//   When defined, adds an output 'ovf' that reports signed two's-complement
//   overflow of the completed add. It is valid together with 'done'.
//
// Parameters:
//   WIDTH  operand/sum width; must be a multiple of 4 and at least 4.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request an add; honoured only in IDLE or DONE
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   c_in   in   1      carry into nibble 0, captured on the accepted start edge
//   busy   out  1      high while nibbles are being processed (RUN)
//   done   out  1      one-cycle pulse; s and c_out are final while high
//   s      out  WIDTH  sum register (partial nibbles visible during RUN)
//   c_out  out  1      carry out of the most significant nibble
//   ovf    out  1      signed overflow (only with NSA_OVERFLOW_EN)
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder slice: all carries are computed in parallel
// from generate/propagate terms.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carry equations, flattened so that no carry ripples.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / 4;
  // The index counter is at least one bit wide, even when N == 1.
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             last_nib;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [3:0]       slice_s;
  logic             slice_c;
  logic [WIDTH-1:0] s_next;

  // A start is honoured only in IDLE or DONE; in DONE this gives the
  // back-to-back path with no IDLE cycle in between.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_nib = (idx == LAST_IDX);

  // Bring the current nibble down to bit 0 so that the slice always
  // reads bits [3:0].
  assign a_shift = a_reg >> {idx, 2'b00};
  assign b_shift = b_reg >> {idx, 2'b00};

  cla_4bit u_cla (
    .a     (a_shift[3:0]),
    .b     (b_shift[3:0]),
    .c_in  (carry_reg),
    .s     (slice_s),
    .c_out (slice_c)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Merge the slice sum into the nibble of s selected by idx.
  always_comb begin
    s_next = s;
    for (int i = 0; i < N; i++) begin
      if (idx == i[IDX_W-1:0]) begin
        s_next[4*i +: 4] = slice_s;
      end else begin
        s_next[4*i +: 4] = s[4*i +: 4];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_nib) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, then process one nibble per RUN
  // edge. The final carry (and overflow) is committed on the last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      s         <= '0;
      c_out     <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= c_in;
      idx       <= '0;
      s         <= '0;
      c_out     <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (state == RUN) begin
      s         <= s_next;
      carry_reg <= slice_c;
      if (last_nib) begin
        c_out <= slice_c;
`ifdef NSA_OVERFLOW_EN
        // Like-signed operands whose sum sign differs overflow.
        ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (slice_s[3] != a_reg[WIDTH-1]);
`endif
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      idx <= idx;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed self-checking bench for nibble_serial_adder with WIDTH = 16.
// Expected sums are hand-computed constants. Outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        c_out;
`ifdef NSA_OVERFLOW_EN
  logic        ovf;
`endif

  int n_cmp;
  int n_err;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a start pulse; returns at the negedge after the accept edge.
  task automatic start_add(input logic [15:0] av, input logic [15:0] bv,
                           input logic cv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    c_in  = cv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; counts the sampled cycles in which busy was high.
  task automatic wait_done(output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    while (!done && guard < 20) begin
      if (busy) nbusy++;
      guard++;
      @(negedge clk);
    end
  endtask

  // Full add with checks; returns at the negedge where done is high.
  task automatic run_add(input string tag, input logic [15:0] av,
                         input logic [15:0] bv, input logic cv,
                         input logic [15:0] exp_s, input logic exp_c);
    int nb;
    start_add(av, bv, cv);
    wait_done(nb);
    check_val({tag, "_busy_cycles"}, 32'(nb), 32'd4);
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    check_val({tag, "_s"}, {16'd0, s}, {16'd0, exp_s});
    check_val({tag, "_cout"}, {31'd0, c_out}, {31'd0, exp_c});
  endtask

  initial begin
    int nb;
    int ndone;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    c_in  = 1'b0;

    // Reset values.
    #12;
    check_val("rst_s", {16'd0, s}, 32'd0);
    check_val("rst_cout", {31'd0, c_out}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add with the carry crossing one nibble; done is a single pulse.
    run_add("t1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    @(negedge clk);
    check_val("t1_done_pulse", {31'd0, done}, 32'd0);
    check_val("t1_s_hold", {16'd0, s}, 32'h0000_0100);

    // Carry ripples through all four nibbles.
    run_add("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

    // Maximal operands with carry-in.
    run_add("t2b", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Carry-in used, then back-to-back start held in DONE.
    run_add("t3", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    start = 1'b1;
    a     = 16'h0001;
    b     = 16'h0001;
    c_in  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_val("t3_b2b_busy", {31'd0, busy}, 32'd1);
    check_val("t3_b2b_s_clr", {16'd0, s}, 32'd0);
    wait_done(nb);
    check_val("t3b_busy_cycles", 32'(nb), 32'd4);
    check_val("t3b_done", {31'd0, done}, 32'd1);
    check_val("t3b_s", {16'd0, s}, 32'h0000_0002);
    check_val("t3b_cout", {31'd0, c_out}, 32'd0);

    // Start and operand changes during RUN are ignored.
    start_add(16'h1111, 16'h2222, 1'b0);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    c_in  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        check_val("t4_s", {16'd0, s}, 32'h0000_3333);
        check_val("t4_cout", {31'd0, c_out}, 32'd0);
      end
      @(negedge clk);
    end
    check_val("t4_done_count", 32'(ndone), 32'd1);

    // Reset asserted in the second RUN cycle aborts the add.
    start_add(16'hABCD, 16'h1357, 1'b1);
    @(negedge clk);
    check_val("t5_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t5_s", {16'd0, s}, 32'd0);
    check_val("t5_cout", {31'd0, c_out}, 32'd0);
    check_val("t5_busy", {31'd0, busy}, 32'd0);
    check_val("t5_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_val("t5_no_done", 32'(ndone), 32'd0);
    run_add("t5_fresh", 16'hABCD, 16'h1357, 1'b1, 16'hBF25, 1'b0);

`ifdef NSA_OVERFLOW_EN
    run_add("ov1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    check_val("ov1_ovf", {31'd0, ovf}, 32'd1);
    run_add("ov2", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    check_val("ov2_ovf", {31'd0, ovf}, 32'd1);
    run_add("ov3", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    check_val("ov3_ovf", {31'd0, ovf}, 32'd0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
